// File: rtl/mop_queue_pkg.sv
// Shared types for the micro-op queue: the micro-op record, group-count type and ring entry.
package mop_queue_pkg;

  localparam int MAX_MOP_CNT = 6;
  localparam int CNT_W       = $clog2(MAX_MOP_CNT + 1);

  typedef logic [CNT_W-1:0] mop_cnt_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [63:0] rip_val;
    logic [31:0] disp;
    logic [31:0] imm;
    logic [1:0]  scale;
  } micro_op_t;

  typedef struct packed {
    micro_op_t mop;
    logic      last;
  } mopq_entry_t;

endpackage

// File: rtl/mop_queue.sv
// Ring buffer that accepts whole micro-op groups from the cracker and issues one mop per cycle.
module mop_queue
  import mop_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  mop_cnt_t                   in_cnt,
  input  micro_op_t                  in_mops [MAX_MOP_CNT],
  output logic                       out_valid,
  input  logic                       out_ready,
  output micro_op_t                  out_mop,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  mopq_entry_t mem_q [DEPTH];
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  occ_t        count_q, count_d;
  logic        ready_en_q;
  logic        enq_fire;
  logic        deq_fire;

  // Readiness reserves room for a worst-case group, so it never depends on in_cnt or out_ready.
  assign in_ready  = reset_n && ready_en_q && !flush &&
                     ((occ_t'(DEPTH) - count_q) >= occ_t'(MAX_MOP_CNT));
  assign out_valid = (count_q != '0);
  assign enq_fire  = in_valid && in_ready;
  assign deq_fire  = out_valid && out_ready;
  assign out_mop   = out_valid ? mem_q[head_q].mop  : '0;
  assign out_last  = out_valid ? mem_q[head_q].last : 1'b0;
  assign occupancy = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + ptr_t'(in_cnt);
      end
      if (deq_fire) begin
        head_d = head_q + ptr_t'(1);
      end
      count_d = count_q + occ_t'(enq_fire ? in_cnt : mop_cnt_t'(0)) - occ_t'(deq_fire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Whole group lands on a single edge; only the final mop of the group carries last.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      assert (int'(in_cnt) <= MAX_MOP_CNT)
        else $fatal(1, "ERROR: mop_queue in_cnt=%0d exceeds MAX_MOP_CNT=%0d", in_cnt, MAX_MOP_CNT);
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (i < int'(in_cnt)) begin
          mem_q[tail_q + ptr_t'(i)].mop  <= in_mops[i];
          mem_q[tail_q + ptr_t'(i)].last <= (i == int'(in_cnt) - 1);
        end
      end
    end
  end

endmodule
